pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MULDIV_LAT, default 4: total cycles a mult/div op occupies EX; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 hz_stall  input  1  load-use stall request from hazard detection (ID stage).
REQ-006 branch_taken  input  1  taken branch/jump resolved in EX.
REQ-007 muldiv_start  input  1  EX holds a mult/div op; stays high while that op is held in EX.
REQ-008 mem_access  input  1  MEM stage holds a load/store.
REQ-009 dmem_ready  input  1  data memory ready.
REQ-010 imem_ready  input  1  instruction memory ready.
REQ-011 pc_write, ifid_write, idex_write, exmem_write  output  1 each  stage register write enables.
REQ-012 ifid_flush, idex_bubble, exmem_bubble, memwb_bubble  output  1 each  load NOP into that register.
REQ-013 state  output  1  0=RUN, 1=MULDIV.
REQ-014 stall_count  output  CNT_W  cycles with pc_write=0; flush_count  output  CNT_W  branch flushes.

Function
REQ-015 Outputs SHALL be combinational from registered state plus current inputs; no added latency.
REQ-016 Per-cycle condition priority SHALL be: mem_stall > muldiv_stall > branch > load_use > fetch_wait > run.
REQ-017 mem_stall = mem_access & !dmem_ready, in any state: all four write enables 0, memwb_bubble=1, other bubbles/flush 0.
REQ-018 muldiv_stall = (RUN & muldiv_start & MULDIV_LAT>1) | (MULDIV & cnt!=0): pc_write=ifid_write=idex_write=0, exmem_write=1, exmem_bubble=1.
REQ-019 branch: all write enables 1, ifid_flush=1, idex_bubble=1; overrides hz_stall and imem_ready.
REQ-020 load_use (hz_stall): pc_write=ifid_write=0, idex_bubble=1, idex_write=exmem_write=1.
REQ-021 fetch_wait (!imem_ready): pc_write=0, ifid_flush=1, other write enables 1.
REQ-022 run: all write enables 1, all bubbles/flush 0.
REQ-023 RUN->MULDIV when muldiv_start & !mem_stall & MULDIV_LAT>1; cnt loads MULDIV_LAT-2.
REQ-024 In MULDIV, cnt SHALL decrement by 1 each cycle without mem_stall and hold during mem_stall.
REQ-025 In MULDIV with cnt==0 and no mem_stall: run outputs (op retires to EX/MEM), next state RUN; muldiv_start ignored this cycle.
REQ-026 muldiv_start in MULDIV state SHALL never restart the counter.
REQ-027 MULDIV_LAT=1: muldiv_start has no effect; state stays RUN.
REQ-028 Op in EX SHALL occupy exactly MULDIV_LAT non-mem_stall cycles.
REQ-029 stall_count SHALL increment on every cycle with pc_write=0; flush_count on every branch cycle; both saturate at all-ones.
REQ-030 cnt width 8 bits.

Reset
REQ-031 reset_n low SHALL immediately force state=RUN, cnt=0, stall_count=0, flush_count=0, including mid-MULDIV.
REQ-032 While reset_n low: all write enables 0, all bubbles/flush 1; counters do not count.
REQ-033 First cycle after reset_n rises SHALL evaluate as RUN with normal priority.

Structure
REQ-034 Shared package SHALL hold state encodings RUN/MULDIV and the default MULDIV_LAT.
REQ-035 One sub-module: sat_counter (CNT_W-bit saturating increment with enable), instantiated twice.
REQ-036 No other sub-modules; condition decode and FSM live in pipeline_controller.

Verification
REQ-037 hz_stall=1 one cycle in RUN -> pc_write=0, ifid_write=0, idex_bubble=1; stall_count 0->1.
REQ-038 muldiv_start held, MULDIV_LAT=4 -> 3 stall cycles (exmem_bubble=1), 4th cycle all writes 1, state RUN; stall_count=3.
REQ-039 MULDIV with cnt=1, mem_access=1, dmem_ready=0 for 2 cycles -> memwb_bubble=1, cnt holds 1; op retires 2 cycles after dmem_ready=1.
REQ-040 branch_taken=1 with hz_stall=1 and imem_ready=0 -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count +1.
REQ-041 reset_n low in MULDIV with cnt=2 -> state=0, counters 0, writes 0, bubbles 1 without a clock edge.
REQ-042 Force stall_count to all-ones, then hz_stall=1 -> stall_count stays all-ones.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_controller_pkg : shared FSM encodings and defaults for the
//                           pipeline controller.                 rev 1.0
// ============================================================================
package pipeline_controller_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_e;

    localparam int DEFAULT_MULDIV_LAT = 4;
    localparam int MD_CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/pipeline_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : W-bit up counter with enable that sticks at all-ones.
//                                                                rev 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// pipeline_controller : stall/flush/bubble control for a 5-stage pipeline
//                       with a multi-cycle mult/div unit in EX.  rev 1.0
// ============================================================================
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int MULDIV_LAT = DEFAULT_MULDIV_LAT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hz_stall,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic             state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic                MULDIV_EN = (MULDIV_LAT > 1);
    // The entry cycle and the retire cycle are both part of the op's EX time.
    localparam logic [MD_CNT_W-1:0] CNT_LOAD  =
        MULDIV_EN ? MD_CNT_W'(MULDIV_LAT - 2) : '0;

    state_e              cur_state;
    logic [MD_CNT_W-1:0] cnt;

    logic mem_stall;
    logic muldiv_stall;
    logic branch_cyc;

    assign mem_stall    = mem_access & ~dmem_ready;
    assign muldiv_stall = ((cur_state == ST_RUN) & muldiv_start & MULDIV_EN) |
                          ((cur_state == ST_MULDIV) & (cnt != '0));
    assign branch_cyc   = reset_n & ~mem_stall & ~muldiv_stall & branch_taken;
    assign state        = cur_state;

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        if (!reset_n) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            memwb_bubble = 1'b1;
        end else if (muldiv_stall) begin
            exmem_write  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hz_stall) begin
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            idex_bubble = 1'b1;
        end else if (!imem_ready) begin
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            ifid_flush  = 1'b1;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
        end
    end

    // A memory stall freezes the mult/div countdown along with the pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= ST_RUN;
            cnt       <= '0;
        end else begin
            case (cur_state)
                ST_RUN: begin
                    if (muldiv_start && !mem_stall && MULDIV_EN) begin
                        cur_state <= ST_MULDIV;
                        cnt       <= CNT_LOAD;
                    end
                end
                ST_MULDIV: begin
                    if (!mem_stall) begin
                        if (cnt == '0) begin
                            cur_state <= ST_RUN;
                        end else begin
                            cnt <= cnt - MD_CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (reset_n & ~pc_write),
        .count   (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (branch_cyc),
        .count   (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// tb_pipeline_controller : directed self-checking bench for the pipeline
//                          controller.                           rev 1.0
// ============================================================================
module tb_pipeline_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, hz_stall, branch_taken, muldiv_start;
    logic mem_access, dmem_ready, imem_ready;

    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;
    logic        state;
    logic [31:0] stall_count, flush_count;

    logic        pc_write2, ifid_write2, idex_write2, exmem_write2;
    logic        ifid_flush2, idex_bubble2, exmem_bubble2, memwb_bubble2;
    logic        state2;
    logic [1:0]  stall_count2, flush_count2;

    logic [7:0]  ctl;
    assign ctl = {pc_write, ifid_write, idex_write, exmem_write,
                  ifid_flush, idex_bubble, exmem_bubble, memwb_bubble};

    // Control vector codes {pc,ifid,idex,exmem writes, flush, 3 bubbles}
    localparam logic [7:0] C_RUN  = 8'hF0;
    localparam logic [7:0] C_MEM  = 8'h01;
    localparam logic [7:0] C_MD   = 8'h12;
    localparam logic [7:0] C_BR   = 8'hFC;
    localparam logic [7:0] C_LU   = 8'h34;
    localparam logic [7:0] C_FW   = 8'h78;
    localparam logic [7:0] C_RST  = 8'h0F;

    pipeline_controller #(.MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .hz_stall(hz_stall),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .memwb_bubble(memwb_bubble), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_controller #(.MULDIV_LAT(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .hz_stall(hz_stall),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_write(pc_write2), .ifid_write(ifid_write2), .idex_write(idex_write2),
        .exmem_write(exmem_write2), .ifid_flush(ifid_flush2),
        .idex_bubble(idex_bubble2), .exmem_bubble(exmem_bubble2),
        .memwb_bubble(memwb_bubble2), .state(state2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; hz_stall = 1'b0; branch_taken = 1'b0; muldiv_start = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
        #2;
        chk("rst_ctl",   ctl, C_RST);
        chk("rst_state", state, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_cnt",   dut.cnt, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("run_ctl", ctl, C_RUN);
        tick();
        chk("run_stall", stall_count, 0);

        // load-use stall
        hz_stall = 1'b1;
        #1;
        chk("lu_ctl", ctl, C_LU);
        tick();
        hz_stall = 1'b0;
        chk("lu_stall", stall_count, 1);

        // fetch wait
        imem_ready = 1'b0;
        #1;
        chk("fw_ctl", ctl, C_FW);
        tick();
        imem_ready = 1'b1;
        chk("fw_stall", stall_count, 2);

        // branch overrides load-use and fetch wait
        branch_taken = 1'b1; hz_stall = 1'b1; imem_ready = 1'b0;
        #1;
        chk("br_ctl", ctl, C_BR);
        tick();
        branch_taken = 1'b0; hz_stall = 1'b0; imem_ready = 1'b1;
        chk("br_flush", flush_count, 1);
        chk("br_stall", stall_count, 2);

        // mult/div with latency 4, start held throughout
        muldiv_start = 1'b1;
        #1;
        chk("md1_ctl",    ctl, C_MD);
        chk("md1_state",  state, 0);
        chk("lat1_pcw",   pc_write2, 1);
        tick();
        chk("md2_state",  state, 1);
        chk("md2_cnt",    dut.cnt, 2);
        chk("md2_ctl",    ctl, C_MD);
        chk("lat1_state", state2, 0);
        tick();
        chk("md3_cnt",    dut.cnt, 1);
        chk("md3_ctl",    ctl, C_MD);
        tick();
        chk("md4_cnt",    dut.cnt, 0);
        chk("md4_ctl",    ctl, C_RUN);
        chk("md4_state",  state, 1);
        tick();
        muldiv_start = 1'b0;
        chk("md_done_state", state, 0);
        chk("md_done_stall", stall_count, 5);

        // mult/div interrupted by memory stall at cnt=1
        muldiv_start = 1'b1;
        tick();
        tick();
        chk("ms_cnt1", dut.cnt, 1);
        mem_access = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("ms1_ctl", ctl, C_MEM);
        tick();
        chk("ms1_cnt", dut.cnt, 1);
        chk("ms2_ctl", ctl, C_MEM);
        tick();
        chk("ms2_cnt",   dut.cnt, 1);
        chk("ms2_state", state, 1);
        mem_access = 1'b0; dmem_ready = 1'b1;
        #1;
        chk("ms3_ctl", ctl, C_MD);
        tick();
        chk("ms4_ctl", ctl, C_RUN);
        tick();
        muldiv_start = 1'b0;
        chk("ms_done_state", state, 0);
        chk("ms_done_stall", stall_count, 10);

        // asynchronous reset mid-MULDIV
        muldiv_start = 1'b1;
        tick();
        chk("ar_cnt_pre", dut.cnt, 2);
        reset_n = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_cnt",   dut.cnt, 0);
        chk("ar_stall", stall_count, 0);
        chk("ar_flush", flush_count, 0);
        chk("ar_ctl",   ctl, C_RST);
        muldiv_start = 1'b0;
        hz_stall = 1'b1;
        tick();
        chk("ar_hold_stall", stall_count, 0);
        hz_stall = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_ctl", ctl, C_RUN);
        tick();
        chk("post_rst_state", state, 0);

        // saturation on the 2-bit counter instance
        hz_stall = 1'b1;
        tick();
        tick();
        tick();
        chk("sat_at3", stall_count2, 2'b11);
        tick();
        chk("sat_hold",   stall_count2, 2'b11);
        chk("sat_wide",   stall_count, 4);
        hz_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
